// File: rtl/rx_dispatch_pkg.sv
// Shared constants for the receive stream dispatcher: channel count,
// FSM state encoding and the default header magic value.
package rx_dispatch_pkg;

    localparam int unsigned NUM_CH = 4;

    localparam logic [5:0] DEFAULT_HDR_MAGIC = 6'h28;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DROP    = 2'd2
    } disp_state_e;

    // True when the upper six bits of a header byte carry the expected magic.
    function automatic logic hdr_magic_ok(input logic [7:0] hdr, input logic [5:0] magic);
        return (hdr[7:2] == magic);
    endfunction

endpackage

// File: rtl/rx_frame_counter.sv
// Frame event counter: increments on inc, either saturating at all-ones
// or wrapping modulo 2^CNT_W depending on SATURATE.
module rx_frame_counter #(
    parameter int unsigned CNT_W    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_q
);

    logic [CNT_W-1:0] cnt_d;

    // Next count: hold, increment, or hold at all-ones when saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            if (SATURATE && (cnt_q == {CNT_W{1'b1}})) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_stream_dispatcher.sv
// Receive stream dispatcher: parses the first byte of each frame as a
// header (magic + channel select), then forwards the payload to the
// selected channel one cycle later, or silently discards the frame.
module rx_stream_dispatcher
    import rx_dispatch_pkg::*;
#(
    parameter logic [5:0]  HDR_MAGIC = DEFAULT_HDR_MAGIC,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       recv_data,
    input  logic             recv_datav,
    input  logic             recv_error,
    input  logic             recv_last,
    input  logic             ch0_ready,
    input  logic             ch1_ready,
    input  logic             ch2_ready,
    input  logic             ch3_ready,
    output logic [7:0]       ch0_data,
    output logic             ch0_datavalid,
    output logic             ch0_error,
    output logic             ch0_last,
    output logic [7:0]       ch1_data,
    output logic             ch1_datavalid,
    output logic             ch1_error,
    output logic             ch1_last,
    output logic [7:0]       ch2_data,
    output logic             ch2_datavalid,
    output logic             ch2_error,
    output logic             ch2_last,
    output logic [7:0]       ch3_data,
    output logic             ch3_datavalid,
    output logic             ch3_error,
    output logic             ch3_last,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] ch0_frame_cnt,
    output logic [CNT_W-1:0] ch1_frame_cnt,
    output logic [CNT_W-1:0] ch2_frame_cnt,
    output logic [CNT_W-1:0] ch3_frame_cnt,
    output logic [1:0]       dispatcher_state
);

    disp_state_e state_q, state_d;
    logic [1:0]  sel_q, sel_d;

    logic [NUM_CH-1:0][7:0] data_q, data_d;
    logic [NUM_CH-1:0]      datavalid_q, datavalid_d;
    logic [NUM_CH-1:0]      error_q, error_d;
    logic [NUM_CH-1:0]      last_q, last_d;

    logic [NUM_CH-1:0]      ready_s;
    logic [1:0]             hdr_sel_s;
    logic                   drop_inc_s;
    logic [NUM_CH-1:0]      frame_inc_s;
    logic [NUM_CH-1:0][CNT_W-1:0] frame_cnt_s;

    assign ready_s   = {ch3_ready, ch2_ready, ch1_ready, ch0_ready};
    assign hdr_sel_s = recv_data[1:0];

    // Next-state, channel latch, per-channel output and counter-increment logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        data_d      = '0;
        datavalid_d = 4'b0000;
        error_d     = 4'b0000;
        last_d      = 4'b0000;
        drop_inc_s  = 1'b0;
        frame_inc_s = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (recv_datav) begin
                    if (recv_last) begin
                        // Empty frame: header only, nothing to deliver.
                        drop_inc_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (hdr_magic_ok(recv_data, HDR_MAGIC) && !recv_error &&
                                 ready_s[hdr_sel_s]) begin
                        sel_d   = hdr_sel_s;
                        state_d = ST_FORWARD;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FORWARD: begin
                if (recv_datav) begin
                    datavalid_d[sel_q] = 1'b1;
                    data_d[sel_q]      = recv_data;
                    error_d[sel_q]     = recv_error;
                    last_d[sel_q]      = recv_last;
                    if (recv_last) begin
                        frame_inc_s[sel_q] = 1'b1;
                        state_d            = ST_IDLE;
                    end else begin
                        state_d = ST_FORWARD;
                    end
                end else begin
                    state_d = ST_FORWARD;
                end
            end
            ST_DROP: begin
                if (recv_datav && recv_last) begin
                    drop_inc_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched channel and registered channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            data_q      <= '0;
            datavalid_q <= 4'b0000;
            error_q     <= 4'b0000;
            last_q      <= 4'b0000;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            datavalid_q <= datavalid_d;
            error_q     <= error_d;
            last_q      <= last_d;
        end
    end

    rx_frame_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b1)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc_s),
        .cnt_q (drop_cnt)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_frame_cnt
        rx_frame_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (1'b0)
        ) u_frame_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (frame_inc_s[gi]),
            .cnt_q (frame_cnt_s[gi])
        );
    end

    assign ch0_data      = data_q[0];
    assign ch0_datavalid = datavalid_q[0];
    assign ch0_error     = error_q[0];
    assign ch0_last      = last_q[0];
    assign ch1_data      = data_q[1];
    assign ch1_datavalid = datavalid_q[1];
    assign ch1_error     = error_q[1];
    assign ch1_last      = last_q[1];
    assign ch2_data      = data_q[2];
    assign ch2_datavalid = datavalid_q[2];
    assign ch2_error     = error_q[2];
    assign ch2_last      = last_q[2];
    assign ch3_data      = data_q[3];
    assign ch3_datavalid = datavalid_q[3];
    assign ch3_error     = error_q[3];
    assign ch3_last      = last_q[3];

    assign ch0_frame_cnt = frame_cnt_s[0];
    assign ch1_frame_cnt = frame_cnt_s[1];
    assign ch2_frame_cnt = frame_cnt_s[2];
    assign ch3_frame_cnt = frame_cnt_s[3];

    assign dispatcher_state = state_q;

endmodule

// File: tb/tb_rx_stream_dispatcher.sv
// Directed self-checking bench for rx_stream_dispatcher.
module tb_rx_stream_dispatcher;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] recv_data = 8'h00;
    logic recv_datav = 1'b0, recv_error = 1'b0, recv_last = 1'b0;
    logic ch0_ready = 1'b0, ch1_ready = 1'b0, ch2_ready = 1'b0, ch3_ready = 1'b0;
    logic [7:0] ch0_data, ch1_data, ch2_data, ch3_data;
    logic ch0_datavalid, ch1_datavalid, ch2_datavalid, ch3_datavalid;
    logic ch0_error, ch1_error, ch2_error, ch3_error;
    logic ch0_last, ch1_last, ch2_last, ch3_last;
    logic [CNT_W-1:0] drop_cnt, ch0_frame_cnt, ch1_frame_cnt, ch2_frame_cnt, ch3_frame_cnt;
    logic [1:0] dispatcher_state;

    int errors = 0;
    int checks = 0;

    wire [3:0]  dv   = {ch3_datavalid, ch2_datavalid, ch1_datavalid, ch0_datavalid};
    wire [3:0]  er   = {ch3_error, ch2_error, ch1_error, ch0_error};
    wire [3:0]  ls   = {ch3_last, ch2_last, ch1_last, ch0_last};
    wire [31:0] dat  = {ch3_data, ch2_data, ch1_data, ch0_data};
    wire [63:0] fcnt = {ch3_frame_cnt, ch2_frame_cnt, ch1_frame_cnt, ch0_frame_cnt};

    always #5 clk = ~clk;

    rx_stream_dispatcher #(.HDR_MAGIC(6'h28), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .recv_data(recv_data), .recv_datav(recv_datav),
        .recv_error(recv_error), .recv_last(recv_last),
        .ch0_ready(ch0_ready), .ch1_ready(ch1_ready),
        .ch2_ready(ch2_ready), .ch3_ready(ch3_ready),
        .ch0_data(ch0_data), .ch0_datavalid(ch0_datavalid), .ch0_error(ch0_error), .ch0_last(ch0_last),
        .ch1_data(ch1_data), .ch1_datavalid(ch1_datavalid), .ch1_error(ch1_error), .ch1_last(ch1_last),
        .ch2_data(ch2_data), .ch2_datavalid(ch2_datavalid), .ch2_error(ch2_error), .ch2_last(ch2_last),
        .ch3_data(ch3_data), .ch3_datavalid(ch3_datavalid), .ch3_error(ch3_error), .ch3_last(ch3_last),
        .drop_cnt(drop_cnt),
        .ch0_frame_cnt(ch0_frame_cnt), .ch1_frame_cnt(ch1_frame_cnt),
        .ch2_frame_cnt(ch2_frame_cnt), .ch3_frame_cnt(ch3_frame_cnt),
        .dispatcher_state(dispatcher_state)
    );

    // Present one input beat, clock it in, and settle 1 time unit past the edge.
    task automatic send(input logic [7:0] d, input logic v, input logic e, input logic l);
        recv_data  = d;
        recv_datav = v;
        recv_error = e;
        recv_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send(8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dispatcher_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dispatcher_state); end
        checks++; if (dv !== 4'b0000) begin errors++; $display("FAIL reset_dv got=%b exp=0000", dv); end
        checks++; if ({dat, er, ls} !== 40'h0) begin errors++; $display("FAIL reset_outs got=%h exp=0", {dat, er, ls}); end
        checks++; if (drop_cnt !== 16'h0000) begin errors++; $display("FAIL reset_drop got=%h exp=0000", drop_cnt); end
        checks++; if (fcnt !== 64'h0) begin errors++; $display("FAIL reset_fcnt got=%h exp=0", fcnt); end
    endtask

    task automatic test_forward();
        logic [7:0] pay [3];
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        do_reset();
        ch1_ready = 1'b1;
        send(8'hA1, 1'b1, 1'b0, 1'b0);
        checks++; if (dv !== 4'b0000) begin errors++; $display("FAIL fwd_hdr_dv got=%b exp=0000", dv); end
        checks++; if (dispatcher_state !== 2'd1) begin errors++; $display("FAIL fwd_hdr_state got=%0d exp=1", dispatcher_state); end
        ch1_ready = 1'b0;  // ready is ignored once the header is accepted
        for (int i = 0; i < 3; i++) begin
            send(pay[i], 1'b1, 1'b0, (i == 2));
            checks++; if (dv !== 4'b0010) begin errors++; $display("FAIL fwd_dv[%0d] got=%b exp=0010", i, dv); end
            checks++; if (dat !== {16'h0, pay[i], 8'h00}) begin errors++; $display("FAIL fwd_data[%0d] got=%h exp=%h", i, dat, {16'h0, pay[i], 8'h00}); end
            checks++; if (ls !== ((i == 2) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL fwd_last[%0d] got=%b", i, ls); end
        end
        checks++; if (ch1_frame_cnt !== 16'd1) begin errors++; $display("FAIL fwd_fcnt got=%0d exp=1", ch1_frame_cnt); end
        checks++; if (dispatcher_state !== 2'd0) begin errors++; $display("FAIL fwd_end_state got=%0d exp=0", dispatcher_state); end
        send(8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (dv !== 4'b0000) begin errors++; $display("FAIL fwd_idle_dv got=%b exp=0000", dv); end
    endtask

    task automatic test_not_ready();
        do_reset();
        ch2_ready = 1'b0;
        send(8'hA2, 1'b1, 1'b0, 1'b0);
        checks++; if (dispatcher_state !== 2'd2) begin errors++; $display("FAIL nr_state got=%0d exp=2", dispatcher_state); end
        for (int i = 0; i < 3; i++) begin
            send(8'h70 + 8'(i), 1'b1, 1'b0, (i == 2));
            checks++; if (dv !== 4'b0000) begin errors++; $display("FAIL nr_dv[%0d] got=%b exp=0000", i, dv); end
        end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL nr_drop got=%0d exp=1", drop_cnt); end
        checks++; if (dispatcher_state !== 2'd0) begin errors++; $display("FAIL nr_end_state got=%0d exp=0", dispatcher_state); end
    endtask

    task automatic test_bad_magic();
        do_reset();
        ch0_ready = 1'b1; ch1_ready = 1'b1; ch2_ready = 1'b1; ch3_ready = 1'b1;
        send(8'h52, 1'b1, 1'b0, 1'b0);
        checks++; if (dispatcher_state !== 2'd2) begin errors++; $display("FAIL bm_state got=%0d exp=2", dispatcher_state); end
        send(8'hA1, 1'b1, 1'b0, 1'b0);
        checks++; if (dv !== 4'b0000) begin errors++; $display("FAIL bm_dv0 got=%b exp=0000", dv); end
        send(8'hBB, 1'b1, 1'b0, 1'b1);
        checks++; if (dv !== 4'b0000) begin errors++; $display("FAIL bm_dv1 got=%b exp=0000", dv); end
        send(8'hA3, 1'b1, 1'b0, 1'b0);  // back-to-back header
        checks++; if (dispatcher_state !== 2'd1) begin errors++; $display("FAIL bm_hdr2_state got=%0d exp=1", dispatcher_state); end
        send(8'h44, 1'b1, 1'b0, 1'b1);
        checks++; if (dv !== 4'b1000) begin errors++; $display("FAIL bm_dv3 got=%b exp=1000", dv); end
        checks++; if (dat !== 32'h4400_0000) begin errors++; $display("FAIL bm_data got=%h exp=44000000", dat); end
        checks++; if (ls !== 4'b1000) begin errors++; $display("FAIL bm_last got=%b exp=1000", ls); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bm_drop got=%0d exp=1", drop_cnt); end
        checks++; if (fcnt !== {16'd1, 16'd0, 16'd0, 16'd0}) begin errors++; $display("FAIL bm_fcnt got=%h", fcnt); end
    endtask

    task automatic test_gap_error();
        do_reset();
        ch0_ready = 1'b1;
        send(8'hA0, 1'b1, 1'b0, 1'b0);
        send(8'h55, 1'b1, 1'b0, 1'b0);
        checks++; if ({dv, er, ls} !== 12'b0001_0000_0000) begin errors++; $display("FAIL ge_b0_flags got=%b", {dv, er, ls}); end
        checks++; if (dat !== 32'h0000_0055) begin errors++; $display("FAIL ge_b0_data got=%h exp=00000055", dat); end
        for (int i = 0; i < 2; i++) begin
            send(8'hEE, 1'b0, 1'b1, 1'b1);
            checks++; if ({dv, er, ls, dat} !== 44'h0) begin errors++; $display("FAIL ge_gap[%0d] got=%h exp=0", i, {dv, er, ls, dat}); end
        end
        checks++; if (dispatcher_state !== 2'd1) begin errors++; $display("FAIL ge_gap_state got=%0d exp=1", dispatcher_state); end
        send(8'h66, 1'b1, 1'b1, 1'b1);
        checks++; if ({dv, er, ls} !== 12'b0001_0001_0001) begin errors++; $display("FAIL ge_b1_flags got=%b", {dv, er, ls}); end
        checks++; if (dat !== 32'h0000_0066) begin errors++; $display("FAIL ge_b1_data got=%h exp=00000066", dat); end
        checks++; if (ch0_frame_cnt !== 16'd1 || drop_cnt !== 16'd0) begin errors++; $display("FAIL ge_cnts got fc0=%0d drop=%0d exp 1/0", ch0_frame_cnt, drop_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        ch0_ready = 1'b1; ch1_ready = 1'b1;
        send(8'hA0, 1'b1, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0, 1'b0);
        checks++; if (dv !== 4'b0001) begin errors++; $display("FAIL rm_b0_dv got=%b exp=0001", dv); end
        rst = 1'b1;
        send(8'h02, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        checks++; if ({dv, er, ls, dat} !== 44'h0) begin errors++; $display("FAIL rm_outs got=%h exp=0", {dv, er, ls, dat}); end
        checks++; if (fcnt !== 64'h0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rm_cnts got fcnt=%h drop=%0d", fcnt, drop_cnt); end
        checks++; if (dispatcher_state !== 2'd0) begin errors++; $display("FAIL rm_state got=%0d exp=0", dispatcher_state); end
        send(8'hA1, 1'b1, 1'b0, 1'b0);
        checks++; if (dispatcher_state !== 2'd1 || dv !== 4'b0000) begin errors++; $display("FAIL rm_hdr got state=%0d dv=%b exp 1/0000", dispatcher_state, dv); end
        send(8'h77, 1'b1, 1'b0, 1'b1);
        checks++; if (dv !== 4'b0010 || ch1_data !== 8'h77) begin errors++; $display("FAIL rm_fwd got dv=%b d=%h exp 0010/77", dv, ch1_data); end
        checks++; if (fcnt !== {16'd0, 16'd0, 16'd1, 16'd0}) begin errors++; $display("FAIL rm_fcnt got=%h", fcnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ch0_ready = 1'b1; ch2_ready = 1'b1;
        send(8'hA0, 1'b1, 1'b0, 1'b0);
        send(8'h10, 1'b1, 1'b0, 1'b1);
        checks++; if (dv !== 4'b0001 || ch0_last !== 1'b1) begin errors++; $display("FAIL b2b_f0 got dv=%b last=%b", dv, ch0_last); end
        send(8'hA2, 1'b1, 1'b0, 1'b0);
        checks++; if (dv !== 4'b0000 || dispatcher_state !== 2'd1) begin errors++; $display("FAIL b2b_hdr got dv=%b st=%0d exp 0000/1", dv, dispatcher_state); end
        send(8'h20, 1'b1, 1'b0, 1'b1);
        checks++; if (dv !== 4'b0100 || dat !== 32'h0020_0000) begin errors++; $display("FAIL b2b_f1 got dv=%b d=%h", dv, dat); end
        checks++; if (fcnt !== {16'd0, 16'd1, 16'd0, 16'd1}) begin errors++; $display("FAIL b2b_fcnt got=%h", fcnt); end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        ch0_ready = 1'b1;
        for (int i = 0; i < 65535; i++) send(8'hA0, 1'b1, 1'b0, 1'b1);
        checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=ffff", drop_cnt); end
        for (int i = 0; i < 3; i++) send(8'hA0, 1'b1, 1'b0, 1'b1);
        checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", drop_cnt); end
        checks++; if (dispatcher_state !== 2'd0 || dv !== 4'b0000) begin errors++; $display("FAIL sat_state got st=%0d dv=%b", dispatcher_state, dv); end
        checks++; if (fcnt !== 64'h0) begin errors++; $display("FAIL sat_fcnt got=%h exp=0", fcnt); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_not_ready();
        test_bad_magic();
        test_gap_error();
        test_reset_mid_frame();
        test_back_to_back();
        test_drop_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_stream_dispatcher.md
RX_STREAM_DISPATCHER -- requirements
Module: rx_stream_dispatcher

Interface
REQ-001 SHALL have parameter HDR_MAGIC, default 6'h28, required value of header byte bits[7:2].
REQ-002 SHALL have parameter CNT_W, default 16, width of drop and frame counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have ports recv_data/recv_datav/recv_error/recv_last, input, 8/1/1/1, received byte stream; recv_last is qualified by recv_datav.
REQ-006 SHALL have ports chN_ready, input, 1 each (N=0..3), channel N can accept a whole frame.
REQ-007 SHALL have ports chN_data/chN_datavalid/chN_error/chN_last, output, 8/1/1/1 each (N=0..3), dispatched stream.
REQ-008 SHALL have port drop_cnt, output, CNT_W, count of discarded frames.
REQ-009 SHALL have ports chN_frame_cnt, output, CNT_W each (N=0..3), count of frames delivered to channel N.
REQ-010 SHALL have port dispatcher_state, output, 2, current FSM state for debug.

Function
REQ-011 SHALL treat the first valid byte of each frame as a header: bits[1:0] select the channel, bits[7:2] must equal HDR_MAGIC.
REQ-012 SHALL implement the FSM states IDLE=0, FORWARD=1 and DROP=2.
REQ-013 In IDLE with recv_datav=1 and recv_last=0, SHALL go to FORWARD when magic matches, recv_error=0 and ch[sel]_ready=1, else go to DROP.
REQ-014 In IDLE, a header byte with recv_last=1 (empty frame) SHALL be discarded, increment drop_cnt, and the FSM SHALL stay in IDLE.
REQ-015 Header byte SHALL never be forwarded.
REQ-016 SHALL latch the selected channel at the header; chN_ready SHALL be ignored after the header until frame end.
REQ-017 In FORWARD, each recv_datav=1 byte SHALL appear on the selected channel exactly 1 cycle later, with data, error and last copied.
REQ-018 Non-selected channels' chN_datavalid SHALL be 0, and their data/error/last SHALL be 0.
REQ-019 Gaps (recv_datav=0) SHALL produce chN_datavalid=0 with data/error/last held at 0.
REQ-020 In FORWARD, recv_last=1 with recv_datav=1 SHALL return the FSM to IDLE and increment chN_frame_cnt of the selected channel.
REQ-021 In DROP, SHALL consume bytes without output; recv_last=1 with recv_datav=1 SHALL return the FSM to IDLE and increment drop_cnt on that cycle.
REQ-022 recv_error mid-frame in FORWARD SHALL be passed through, SHALL NOT abort the frame and SHALL NOT change counters.
REQ-023 drop_cnt SHALL saturate at all-ones; chN_frame_cnt SHALL wrap modulo 2^CNT_W.
REQ-024 A back-to-back header in the cycle after recv_last SHALL be accepted with no idle cycle required.

Reset
REQ-025 When rst=1, SHALL force IDLE; all chN_data/datavalid/error/last SHALL be 0; drop_cnt and all chN_frame_cnt SHALL be 0.
REQ-026 Reset mid-frame SHALL abort the frame without asserting chN_last and without any counter increment; the first valid byte after reset SHALL be treated as a header.

Structure
REQ-027 Package rx_dispatch_pkg SHALL hold NUM_CH=4, the state encoding constants and the default HDR_MAGIC.
REQ-028 Counters SHALL use one sub-module rx_frame_counter (parameters CNT_W and SATURATE), instantiated 5 times.

Verification
REQ-029 Header 0xA1, then 0x11,0x22,0x33 (last) with ch1_ready=1 -> ch1 outputs 0x11,0x22,0x33 on cycles H+2..H+4; ch1_last only with 0x33; ch1_frame_cnt=1.
REQ-030 Header 0xA2 with ch2_ready=0, then 3 bytes -> no chN_datavalid; drop_cnt=1; FSM returns to IDLE.
REQ-031 Header 0x52 (bad magic), then 2 bytes, then header 0xA3 + 0x44 (last) -> only ch3 outputs 0x44; drop_cnt=1; ch3_frame_cnt=1.
REQ-032 Header 0xA0 + 0x55, 2-cycle datav gap, 0x66 (last, recv_error=1) -> ch0 outputs 0x55 then 0x66 with ch0_error=1 and ch0_last=1; frame_cnt=1.
REQ-033 rst=1 asserted on the 2nd payload byte of a ch0 frame -> all outputs 0 next cycle; next byte 0xA1 is parsed as a header.
REQ-034 Drive 2^CNT_W+2 empty frames (header 0xA0 with last) -> drop_cnt holds at all-ones.
